trace_buffer: RTL and testbench

Debug trace capture for the RV32I pipeline. Consumes the datapath's debug outputs (`dbg_PCF`, `dbg_InstrD`, `dbg_ALUResultE`) plus `StallD`. It records them into a circular buffer while armed, freezes on a PC-match trigger after a programmable post-trigger count, then streams the captured history oldest-first over a valid/ready port. It sits beside `datapath` at the top level as the reader of its debug interface.

---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/trace_buffer_if.sv | 15 +
 rtl/trace_ram.sv | 28 ++
 rtl/trace_buffer.sv | 132 +++++++++++++
 tb/tb_trace_buffer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline debug-trace capture block.
// Latency: n/a (types only). Backpressure: n/a.
// Entry layout puts PC in the top 32 bits of the 96-bit word.
package pipeline_pkg;

    localparam int TRACE_ENTRY_W = 96;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu_result;
    } trace_entry_t;

    typedef enum logic [2:0] {
        TS_IDLE,
        TS_ARMED,
        TS_POST,
        TS_DONE,
        TS_READ
    } trace_state_t;

endpackage

// File: rtl/trace_buffer_if.sv
// Readout stream of the trace buffer: one captured entry per accepted beat.
// Latency: combinational bundle. Backpressure: RdReady stalls, data held stable.
// master = trace_buffer side, slave = consumer side.
interface trace_buffer_if;
    import pipeline_pkg::*;

    logic         RdValid;
    logic         RdReady;
    logic         RdLast;
    trace_entry_t RdData;

    modport master (output RdValid, output RdData, output RdLast, input RdReady);
    modport slave  (input RdValid, input RdData, input RdLast, output RdReady);

endinterface

// File: rtl/trace_ram.sv
// DEPTH x 96 trace storage, no reset.
// Latency: write lands on the next edge, read is combinational.
// Backpressure: none.
module trace_ram
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  trace_entry_t  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output trace_entry_t  rdata_o
);

    trace_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/trace_buffer.sv
// Circular debug-trace capture with PC trigger, post-trigger count, oldest-first dump.
// Latency: DONE one cycle after the final post-trigger sample, first beat the cycle after.
// Backpressure: RdReady low holds the current entry; capture never stalls the pipeline.
module trace_buffer
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallD,
    input  logic [31:0] dbg_PCF,
    input  logic [31:0] dbg_InstrD,
    input  logic [31:0] dbg_ALUResultE,
    input  logic        Arm,
    input  logic [31:0] TrigPC,
    input  logic [AW:0] PostCount,
    trace_buffer_if.master rd,
    output logic        Armed,
    output logic        Triggered,
    output logic        Done
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] ZERO = '0;

    trace_state_t  state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic [AW:0]   post_left_q, post_left_d;
    logic [AW:0]   rd_left_q, rd_left_d;
    logic          we;
    logic          sample;
    trace_entry_t  wdata;

    assign sample = !StallD;
    assign wdata  = '{pc: dbg_PCF, instr: dbg_InstrD, alu_result: dbg_ALUResultE};

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_q;
        post_left_d = post_left_q;
        rd_left_d   = rd_left_q;
        we          = 1'b0;

        // ARMED and POST share the write path; only trigger/decrement differ.
        if ((state_q == TS_ARMED || state_q == TS_POST) && sample) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            fill_d   = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
        end

        case (state_q)
            TS_IDLE: begin
                if (Arm) begin
                    state_d     = TS_ARMED;
                    wr_ptr_d    = '0;
                    fill_d      = ZERO;
                    post_left_d = (PostCount > FULL) ? FULL : PostCount;
                end
            end
            TS_ARMED: begin
                if (sample && dbg_PCF == TrigPC) begin
                    state_d = (post_left_q == ZERO) ? TS_DONE : TS_POST;
                end
            end
            TS_POST: begin
                if (sample) begin
                    post_left_d = post_left_q - 1'b1;
                    if (post_left_q == ONE) begin
                        state_d = TS_DONE;
                    end
                end
            end
            TS_DONE: begin
                // Once wrapped, the slot about to be overwritten holds the oldest entry.
                rd_ptr_d  = (fill_q == FULL) ? wr_ptr_q : '0;
                rd_left_d = fill_q;
                state_d   = TS_READ;
            end
            TS_READ: begin
                if (rd.RdReady) begin
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                    rd_left_d = rd_left_q - 1'b1;
                    if (rd_left_q == ONE) begin
                        state_d = TS_IDLE;
                    end
                end
            end
            default: state_d = TS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= TS_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            post_left_q <= '0;
            rd_left_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            post_left_q <= post_left_d;
            rd_left_q   <= rd_left_d;
        end
    end

    trace_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd.RdData)
    );

    assign rd.RdValid = (state_q == TS_READ);
    assign rd.RdLast  = (state_q == TS_READ) && (rd_left_q == ONE);
    assign Armed      = (state_q == TS_ARMED);
    assign Triggered  = (state_q == TS_POST);
    assign Done       = (state_q == TS_DONE) || (state_q == TS_READ);

endmodule

// File: tb/tb_trace_buffer.sv
// Directed + randomized bench for trace_buffer against a queue-based capture model.
module tb_trace_buffer;
    import pipeline_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallD;
    logic [31:0] dbg_PCF, dbg_InstrD, dbg_ALUResultE, TrigPC;
    logic        Arm;
    logic [AW:0] PostCount;
    logic        Armed, Triggered, Done;

    trace_buffer_if rd_if();

    trace_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .StallD         (StallD),
        .dbg_PCF        (dbg_PCF),
        .dbg_InstrD     (dbg_InstrD),
        .dbg_ALUResultE (dbg_ALUResultE),
        .Arm            (Arm),
        .TrigPC         (TrigPC),
        .PostCount      (PostCount),
        .rd             (rd_if.master),
        .Armed          (Armed),
        .Triggered      (Triggered),
        .Done           (Done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    trace_entry_t q[$];

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check96(input string tag, input trace_entry_t obs, input trace_entry_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check1({tag, "_rdvalid"}, rd_if.RdValid, 1'b0);
        check1({tag, "_rdlast"}, rd_if.RdLast, 1'b0);
        check1({tag, "_armed"}, Armed, 1'b0);
        check1({tag, "_triggered"}, Triggered, 1'b0);
        check1({tag, "_done"}, Done, 1'b0);
    endtask

    // Model: keep the last DEPTH samples; after the trigger sample, count clamp(post) more.
    task automatic capture(input int post, input logic [31:0] trig, input bit hold4, input int stall_pct);
        int clampd, post_left, phase, held, cycles;
        logic [31:0] pc;
        bit done, smp;
        trace_entry_t e;
        q.delete();
        pc = '0; held = 0; done = 0; cycles = 0; post_left = 0;
        clampd = (post > DEPTH) ? DEPTH : post;
        Arm = 1'b1; PostCount = post[AW:0]; StallD = 1'b1; TrigPC = trig; dbg_PCF = pc;
        tick();
        Arm = 1'b0; phase = 1;
        check1("armed_after_arm", Armed, 1'b1);
        check1("trig_after_arm", Triggered, 1'b0);
        while (!done) begin
            if (cycles >= 2000) begin
                total++; bad++;
                $error("FAIL capture_timeout observed=%0d expected<2000", cycles);
                return;
            end
            cycles++;
            smp = ($urandom_range(99) >= stall_pct);
            if (hold4 && pc == trig && held < 4) begin
                smp = 1'b0;
                held++;
            end
            e.pc = pc; e.instr = $urandom; e.alu_result = $urandom;
            StallD = !smp; dbg_PCF = e.pc; dbg_InstrD = e.instr; dbg_ALUResultE = e.alu_result;
            tick();
            if (smp) begin
                q.push_back(e);
                if (q.size() > DEPTH) void'(q.pop_front());
                if (phase == 1 && pc == trig) begin
                    post_left = clampd;
                    if (post_left == 0) done = 1'b1;
                    else phase = 2;
                end else if (phase == 2) begin
                    post_left--;
                    if (post_left == 0) done = 1'b1;
                end
                pc = pc + 32'd4;
            end
            check1("armed", Armed, !done && phase == 1);
            check1("triggered", Triggered, !done && phase == 2);
            check1("done", Done, done);
            check1("rdvalid_capture", rd_if.RdValid, 1'b0);
        end
        StallD = 1'b0;
    endtask

    // mode 0: ready held high, 1: ready 1,0,0 pattern with Arm noise, 2: random ready.
    task automatic readout(input int mode, input int stop_after);
        int idx, cycles;
        bit rdy;
        idx = 0; cycles = 0;
        rd_if.RdReady = 1'b0;
        tick();
        while (idx < q.size()) begin
            if (stop_after >= 0 && idx == stop_after) break;
            if (cycles >= 400) begin
                total++; bad++;
                $error("FAIL readout_timeout observed=%0d expected<400", cycles);
                break;
            end
            cycles++;
            check1("rdvalid", rd_if.RdValid, 1'b1);
            check96("rddata", rd_if.RdData, q[idx]);
            check1("rdlast", rd_if.RdLast, idx == q.size() - 1);
            check1("done_in_read", Done, 1'b1);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cycles % 3 == 1);
                default: rdy = 1'($urandom_range(1));
            endcase
            rd_if.RdReady = rdy;
            Arm = (mode == 1) ? 1'($urandom_range(1)) : 1'b0;
            PostCount = 5'($urandom_range(31));
            tick();
            if (rdy) idx++;
        end
        rd_if.RdReady = 1'b0;
        Arm = 1'b0;
        if (stop_after < 0) begin
            check1("rdvalid_after", rd_if.RdValid, 1'b0);
            check1("armed_after", Armed, 1'b0);
            check1("done_after", Done, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1; Arm = 1'b0; StallD = 1'b1; TrigPC = '0; PostCount = '0;
        dbg_PCF = '0; dbg_InstrD = '0; dbg_ALUResultE = '0;
        rd_if.RdReady = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();
        check_idle_outputs("idle");

        capture(2, 32'h10, 1'b0, 0);
        readout(0, -1);

        capture(3, 32'h100, 1'b0, 0);
        readout(0, -1);

        capture(0, 32'h08, 1'b0, 0);
        readout(2, -1);

        capture(1, 32'h10, 1'b1, 0);
        readout(0, -1);

        capture(20, 32'h40, 1'b0, 0);
        readout(1, -1);

        for (int r = 0; r < 6; r++) begin
            capture(int'($urandom_range(31)), 32'(4 * $urandom_range(40)), 1'b0, 30);
            readout(1 + (r % 2), -1);
        end

        capture(2, 32'h10, 1'b0, 0);
        readout(0, 2);
        reset = 1'b1;
        tick();
        check_idle_outputs("midread_reset");
        reset = 1'b0;
        capture(2, 32'h10, 1'b0, 0);
        readout(0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
